aqed_fifo_core: RTL

- Synchronous 16-bit FIFO that sits on the far side of the A-QED FIFO monitor.
- It accepts the monitor's `data_out` stream as writes and returns data with a 1-cycle registered read latency.
- It signals `valid_out`, `empty` and `full` exactly as the monitor samples them, so the orig/dup output tracking stays aligned.
- It includes an empty-bypass path (simultaneous write and read while empty) and a clock-enable stall.

---
 rtl/aqed_fifo_core.sv | 74 +++++++
 1 files changed

// File: rtl/aqed_fifo_core.sv
// aqed_fifo_core: 16-bit FIFO with registered read, empty bypass and clock-enable stall
module aqed_fifo_core #(
  parameter int DEPTH = 16,
  parameter int AF_TH = 2,
  parameter int AE_TH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clk_en,
  input  logic                       flush,
  input  logic                       wen,
  input  logic [15:0]                data_in,
  input  logic                       ren,
  output logic [15:0]                data_out,
  output logic                       valid_out,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_empty,
  output logic                       almost_full,
  output logic [$clog2(DEPTH):0]     num_words
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_T = CW'(AF_TH);
  localparam logic [CW-1:0] AE_T = CW'(AE_TH);

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          bypass, rd_acc, wr_acc, push, pop;

  assign empty        = count == '0;
  assign full         = count == DEPTH_C;
  assign almost_empty = count <= AE_T;
  assign almost_full  = (DEPTH_C - count) <= AF_T;
  assign num_words    = count;

  assign bypass = clk_en & ~flush & empty & wen & ren;
  assign rd_acc = clk_en & ren & ~flush & (~empty | bypass);
  assign wr_acc = clk_en & wen & ~flush & (~full | rd_acc);
  assign push   = wr_acc & ~bypass;
  assign pop    = rd_acc & ~bypass;

  // storage write; contents are intentionally left unreset
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= data_in;

  // pointers and occupancy; flush clears, bypass leaves them untouched
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clk_en && flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= (push && !pop) ? count + 1'b1 : (pop && !push) ? count - 1'b1 : count;
    end

  // registered read port: popped or bypassed word appears one cycle after accept
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      data_out  <= '0;
      valid_out <= 1'b0;
    end else if (clk_en) begin
      valid_out <= rd_acc;
      if (rd_acc) data_out <= bypass ? data_in : mem[rd_ptr];
    end
endmodule
